des_key_schedule: RTL and testbench

Iterative DES key schedule that sits directly upstream of the round function's 48-bit key mix. Each subkey it emits is XORed with the expanded right half before that 48-bit value enters the 8-way 6→4 S-box stage. The block loads a 64-bit key and applies PC-1. It then emits the 16 round subkeys one per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1), with consumer backpressure.

---
 rtl/des_pkg.sv | 46 ++++
 rtl/des_pc2.sv | 20 ++
 rtl/des_key_schedule.sv | 172 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES constants: PC-1 / PC-2 index tables, the per-round left-shift
// schedule, the round count and the key-schedule state encoding. Tables use
// DES 1-based, MSB-first bit numbering. Bit n of a W-bit vector maps to
// vector index W-n.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int ROUNDS = 16;
    localparam int HALF_W = 28;
    localparam int CD_W   = 56;
    localparam int KEY_W  = 64;
    localparam int SK_W   = 48;

    // Index of the final subkey within a sequence.
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    // PC-1: output bit i+1 takes key bit PC1[i]. Entries 0..27 form C, 28..55 form D.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: subkey bit j+1 takes {C,D} bit PC2[j].
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount applied before round r+1 (r = 0..15).
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational DES Permuted Choice 2: selects 48 of the 56 {C,D} bits.
// Ports:
//   cd_i      in  56  {C,D}; bit 55 is DES bit 1.
//   subkey_o  out 48  PC-2 result; bit 47 is PC-2 output bit 1.
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);

    // Pure wiring: every output bit is one fixed input bit.
    for (genvar j = 0; j < SK_W; j++) begin : g_pc2
        assign subkey_o[SK_W - 1 - j] = cd_i[CD_W - PC2[j]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Iterative DES key schedule. A start loads PC-1(key) into C/D. The block then
// hands out the 16 round subkeys, one per valid/ready handshake, in encrypt
// order (K1..K16) or decrypt order (K16..K1).
// Ports:
//   clk_i           in   1  clock, rising edge
//   rst_i           in   1  asynchronous active-high reset
//   key_i           in  64  DES key, bit 63 = DES bit 1 (parity bits unused)
//   decrypt_i       in   1  0 = encrypt order, 1 = decrypt order (sampled on start)
//   start_i         in   1  load request, accepted while ready_o = 1
//   ready_o         out  1  idle, start_i will be accepted
//   subkey_o        out 48  PC-2(C,D), bit 47 = PC-2 output bit 1
//   subkey_valid_o  out  1  subkey_o holds a valid subkey
//   subkey_ready_i  in   1  consumer accepts subkey_o
//   round_o         out  4  index of current subkey within the sequence
//   done_o          out  1  one-cycle pulse after the 16th handshake
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        start_i,
    output logic        ready_o,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  round_o,
    output logic        done_o
);

    // 28-bit circular rotations by 0..2 positions.
    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[26:0], v[27]};
            2'd2:    r = {v[25:0], v[27:26]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[0], v[27:1]};
            2'd2:    r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    ks_state_e            state_q;
    logic [HALF_W-1:0]    c_q, d_q;
    logic [HALF_W-1:0]    c_d, d_d;
    logic [3:0]           round_q;
    logic                 mode_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 done_q;

    logic [CD_W-1:0]      pc1_key;
    logic                 load_en;
    logic                 hs_en;
    logic                 unused_parity;

    // PC-1 is fixed wiring from the key. DES bits 8,16,...,64 (parity) are dropped.
    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign pc1_key[CD_W - 1 - i] = key_i[KEY_W - PC1[i]];
    end

    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

    assign load_en = (state_q == ST_IDLE) && start_i;
    assign hs_en   = (state_q == ST_RUN) && subkey_ready_i;

    // Next C/D. Encrypt loads C1/D1 (one left shift past PC-1). Decrypt loads
    // C16/D16, which equals C0/D0 because the schedule totals 28 shifts. Decrypt
    // then walks back with right rotations.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (load_en) begin
            if (decrypt_i) begin
                c_d = pc1_key[55:28];
                d_d = pc1_key[27:0];
            end else begin
                c_d = rotl28(pc1_key[55:28], SHIFT[0]);
                d_d = rotl28(pc1_key[27:0],  SHIFT[0]);
            end
        end else if (hs_en && (round_q != LAST_ROUND)) begin
            if (mode_q) begin
                c_d = rotr28(c_q, SHIFT[LAST_ROUND - round_q]);
                d_d = rotr28(d_q, SHIFT[LAST_ROUND - round_q]);
            end else begin
                c_d = rotl28(c_q, SHIFT[round_q + 4'd1]);
                d_d = rotl28(d_q, SHIFT[round_q + 4'd1]);
            end
        end else begin
            c_d = c_q;
            d_d = d_q;
        end
    end

    // Control FSM, C/D registers and registered handshake/status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            c_q     <= 28'h0;
            d_q     <= 28'h0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            c_q    <= c_d;
            d_q    <= d_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        mode_q  <= decrypt_i;
                        round_q <= 4'd0;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (subkey_ready_i) begin
                        if (round_q == LAST_ROUND) begin
                            state_q <= ST_IDLE;
                            round_q <= 4'd0;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    round_q <= 4'd0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The subkey is PC-2 applied straight to the C/D registers.
    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey_o)
    );

    assign ready_o        = ready_q;
    assign subkey_valid_o = valid_q;
    assign round_o        = round_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk_i;
    logic        rst_i;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        start_i;
    logic        ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        done_o;

    int checks_cnt;
    int errors_cnt;

    logic [47:0] enc_k [16];
    logic [47:0] exp_k [16];

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

    des_key_schedule dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .start_i        (start_i),
        .ready_o        (ready_o),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .subkey_ready_i (subkey_ready_i),
        .round_o        (round_o),
        .done_o         (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode: 0 encrypt order, 1 decrypt order, 2 all zeros, 3 all ones
    task automatic load_exp(input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       exp_k[i] = enc_k[i];
                1:       exp_k[i] = enc_k[15 - i];
                2:       exp_k[i] = 48'h0;
                default: exp_k[i] = 48'hFFFF_FFFF_FFFF;
            endcase
        end
    endtask

    task automatic do_start(input logic [63:0] key, input logic dec);
        check_val("start_ready", 64'(ready_o), 64'd1);
        start_i   = 1'b1;
        key_i     = key;
        decrypt_i = dec;
        @(posedge clk_i); #1;
        start_i   = 1'b0;
        check_val("load_valid", 64'(subkey_valid_o), 64'd1);
    endtask

    // Consume subkeys first..15 against exp_k; optionally raise start on the last one.
    task automatic run_seq(input int first, input bit bp, input bit chain,
                           input logic [63:0] nkey, input logic ndec);
        int stalls;
        for (int i = first; i < 16; i++) begin
            stalls = 0;
            if (bp) begin
                while (stalls < 4 && $urandom_range(0, 1) == 0) begin
                    subkey_ready_i = 1'b0;
                    @(posedge clk_i); #1;
                    check_val("hold_round", 64'(round_o), 64'(i));
                    check_val("hold_subkey", 64'(subkey_o), 64'(exp_k[i]));
                    stalls++;
                end
            end
            subkey_ready_i = 1'b1;
            check_val("round", 64'(round_o), 64'(i));
            check_val("subkey", 64'(subkey_o), 64'(exp_k[i]));
            check_val("valid", 64'(subkey_valid_o), 64'd1);
            check_val("no_done", 64'(done_o), 64'd0);
            if (chain && i == 15) begin
                start_i   = 1'b1;
                key_i     = nkey;
                decrypt_i = ndec;
            end
            @(posedge clk_i); #1;
        end
        subkey_ready_i = 1'b0;
        check_val("done_pulse", 64'(done_o), 64'd1);
        check_val("end_ready", 64'(ready_o), 64'd1);
        check_val("end_valid", 64'(subkey_valid_o), 64'd0);
        check_val("end_round", 64'(round_o), 64'd0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        enc_k[0]  = 48'h1B02EFFC7072; enc_k[1]  = 48'h79AED9DBC9E5;
        enc_k[2]  = 48'h55FC8A42CF99; enc_k[3]  = 48'h72ADD6DB351D;
        enc_k[4]  = 48'h7CEC07EB53A8; enc_k[5]  = 48'h63A53E507B2F;
        enc_k[6]  = 48'hEC84B7F618BC; enc_k[7]  = 48'hF78A3AC13BFB;
        enc_k[8]  = 48'hE0DBEBEDE781; enc_k[9]  = 48'hB1F347BA464F;
        enc_k[10] = 48'h215FD3DED386; enc_k[11] = 48'h7571F59467E9;
        enc_k[12] = 48'h97C5D1FABA41; enc_k[13] = 48'h5F43B7F2E73A;
        enc_k[14] = 48'hBF918D3D3F0A; enc_k[15] = 48'hCB3D8B0E17F5;

        rst_i = 1'b1; key_i = 64'h0; decrypt_i = 1'b0;
        start_i = 1'b0; subkey_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_ready", 64'(ready_o), 64'd1);
        check_val("rst_valid", 64'(subkey_valid_o), 64'd0);
        check_val("rst_subkey", 64'(subkey_o), 64'd0);
        check_val("rst_round", 64'(round_o), 64'd0);
        check_val("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_val("idle_ready", 64'(ready_o), 64'd1);

        // Encrypt, no backpressure
        load_exp(0);
        do_start(KEY_STD, 1'b0);
        run_seq(0, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;
        check_val("done_once", 64'(done_o), 64'd0);

        // Decrypt, reverse order
        load_exp(1);
        do_start(KEY_STD, 1'b1);
        run_seq(0, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;

        // Encrypt with random backpressure
        load_exp(0);
        do_start(KEY_STD, 1'b0);
        run_seq(0, 1'b1, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;

        // start during RUN is ignored; then start held through done chains a zero key
        do_start(KEY_STD, 1'b0);
        subkey_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        subkey_ready_i = 1'b0;
        start_i = 1'b1; key_i = 64'hFFFF_FFFF_FFFF_FFFF; decrypt_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check_val("ign_round", 64'(round_o), 64'd3);
        check_val("ign_subkey", 64'(subkey_o), 64'(enc_k[3]));
        run_seq(3, 1'b0, 1'b1, 64'h0, 1'b0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check_val("chain_valid", 64'(subkey_valid_o), 64'd1);
        check_val("chain_done_low", 64'(done_o), 64'd0);
        load_exp(2);
        run_seq(0, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;

        // Weak keys in the remaining mode combinations
        load_exp(2);
        do_start(64'h0, 1'b1);
        run_seq(0, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;
        load_exp(3);
        do_start(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_seq(0, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;
        do_start(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_seq(0, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk_i); #1;

        // Reset asserted mid-sequence at round 7
        do_start(KEY_STD, 1'b0);
        subkey_ready_i = 1'b1;
        repeat (7) @(posedge clk_i);
        #1;
        subkey_ready_i = 1'b0;
        check_val("pre_rst_round", 64'(round_o), 64'd7);
        check_val("pre_rst_subkey", 64'(subkey_o), 64'(enc_k[7]));
        rst_i = 1'b1;
        #1;
        check_val("mid_rst_ready", 64'(ready_o), 64'd1);
        check_val("mid_rst_valid", 64'(subkey_valid_o), 64'd0);
        check_val("mid_rst_round", 64'(round_o), 64'd0);
        check_val("mid_rst_subkey", 64'(subkey_o), 64'd0);
        check_val("mid_rst_done", 64'(done_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            check_val("post_rst_done", 64'(done_o), 64'd0);
            check_val("post_rst_ready", 64'(ready_o), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
